// File: rtl/ascon_pkg.sv
// Shared Ascon encodings: operation modes, key-XOR strobe codes, sequencer states
// and default round counts. Used by spi_subnode, asconp and ascon_mode_seq.
package ascon_pkg;

   typedef enum logic [2:0] {
      MODE_NOP     = 3'd0,
      MODE_INIT    = 3'd1,
      MODE_AD      = 3'd2,
      MODE_AD_LAST = 3'd3,
      MODE_TEXT    = 3'd4,
      MODE_FINAL   = 3'd5,
      MODE_PERM_A  = 3'd6,
      MODE_PERM_B  = 3'd7
   } mode_t;

   // KEY_S34: K -> S3:S4, KEY_S12: K -> S1:S2
   typedef enum logic [1:0] {
      KEY_NONE = 2'b00,
      KEY_S34  = 2'b01,
      KEY_S12  = 2'b10
   } key_xor_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_START,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } state_t;

   localparam int unsigned DEF_TIMEOUT  = 64;
   localparam int unsigned DEF_ROUNDS_A = 12;
   localparam int unsigned DEF_ROUNDS_B = 6;

   function automatic logic uses_rounds_a(input mode_t m);
      return (m == MODE_INIT) || (m == MODE_FINAL) || (m == MODE_PERM_A);
   endfunction

endpackage

// File: rtl/ascon_toggle_sync.sv
// Brings the sck-domain command toggle into clk: two synchroniser flops, an edge
// register, and a registered one-cycle pulse per toggle flip.
module ascon_toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic toggle_in,
   output logic cmd_pulse
);

   logic sync1;
   logic sync2;
   logic edge_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         edge_q    <= 1'b0;
         cmd_pulse <= 1'b0;
      end else begin
         sync1     <= toggle_in;
         sync2     <= sync1;
         edge_q    <= sync2;
         cmd_pulse <= sync2 ^ edge_q;
      end
   end

endmodule

// File: rtl/ascon_mode_seq.sv
// Per-command Ascon phase sequencer: pre-XOR strobe, permutation start, bounded
// wait for rounds_done, post-XOR strobe, then done/err for SPI status.
module ascon_mode_seq
   import ascon_pkg::*;
#(
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
   parameter int unsigned ROUNDS_A = DEF_ROUNDS_A,
   parameter int unsigned ROUNDS_B = DEF_ROUNDS_B
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_toggle,
   input  logic [2:0] cmd_mode,
   input  logic       perm_done,
   output logic       perm_start,
   output logic [3:0] perm_rounds,
   output logic [1:0] key_xor,
   output logic       dsep_xor,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [3:0] RA = 4'(ROUNDS_A);
   localparam logic [3:0] RB = 4'(ROUNDS_B);

   state_t           state;
   mode_t            mode_q;
   mode_t            cmd_mode_e;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             cmd_pulse;

   assign cmd_mode_e = mode_t'(cmd_mode);
   assign cnt_next   = cnt + CNT_W'(1);

   ascon_toggle_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .toggle_in (cmd_toggle),
      .cmd_pulse (cmd_pulse)
   );

   // Strobes are set on the transition into the state that owns them, so each
   // output is high exactly while the FSM sits in that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         mode_q      <= MODE_NOP;
         cnt         <= '0;
         perm_start  <= 1'b0;
         perm_rounds <= '0;
         key_xor     <= KEY_NONE;
         dsep_xor    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         perm_start <= 1'b0;
         key_xor    <= KEY_NONE;
         dsep_xor   <= 1'b0;
         done       <= 1'b0;

         if (cmd_pulse && (state != ST_IDLE))
            err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (cmd_pulse) begin
                  mode_q <= cmd_mode_e;
                  busy   <= 1'b1;
                  err    <= 1'b0;
                  if (cmd_mode_e == MODE_FINAL)
                     key_xor <= KEY_S12;
                  state  <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (mode_q == MODE_NOP) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  perm_start  <= 1'b1;
                  perm_rounds <= uses_rounds_a(mode_q) ? RA : RB;
                  state       <= ST_START;
               end
            end
            ST_START: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // perm_done takes priority over a timeout in the same cycle
               if (perm_done) begin
                  if ((mode_q == MODE_INIT) || (mode_q == MODE_FINAL))
                     key_xor <= KEY_S34;
                  if (mode_q == MODE_AD_LAST)
                     dsep_xor <= 1'b1;
                  state <= ST_POST;
               end else if (cnt_next == TIMEOUT_C) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt_next;
               end
            end
            ST_POST: begin
               done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
